// File: rtl/alu_share_arbiter_if.sv
// Requester/ALU/response bundle for the shared-ALU arbiter.
// slave = arbiter side, master = requesters plus the ALU itself.
interface alu_share_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op1;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op2;
    logic [NUM_REQ*3-1:0]          req_ctrl;
    logic [DATA_WIDTH-1:0]         alu_op1;
    logic [DATA_WIDTH-1:0]         alu_op2;
    logic [2:0]                    alu_ctrl;
    logic [DATA_WIDTH-1:0]         alu_sum;
    logic                          alu_eq;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [DATA_WIDTH-1:0]         rsp_sum;
    logic                          rsp_eq;
    logic                          busy;

    modport slave (
        input  req_valid, req_op1, req_op2, req_ctrl, alu_sum, alu_eq, rsp_ready,
        output req_ready, alu_op1, alu_op2, alu_ctrl, rsp_valid, rsp_sum, rsp_eq, busy
    );

    modport master (
        output req_valid, req_op1, req_op2, req_ctrl, alu_sum, alu_eq, rsp_ready,
        input  req_ready, alu_op1, alu_op2, alu_ctrl, rsp_valid, rsp_sum, rsp_eq, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one single-cycle ALU; response registered 1 cycle after grant.
// Response held in the owner's slot until accepted; no new grant while a response is pending.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    alu_share_arbiter_if.slave   bus
);
    typedef enum logic {ST_IDLE, ST_RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDW-1:0]        r_last_grant;
    logic [IDW-1:0]        r_owner;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_eq;
    logic                  w_grant_vld;
    logic [IDW-1:0]        w_grant_idx;
    logic [IDW-1:0]        w_cand;
    logic                  w_is_cmp;

    // Search starts just after the last winner and wraps; rst suppresses any grant.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        if (r_state == ST_IDLE && !i_rst) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                w_cand = IDW'((int'(r_last_grant) + k) % NUM_REQ);
                if (!w_grant_vld && bus.req_valid[w_cand]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = w_cand;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.req_ready = '0;
        bus.alu_op1   = '0;
        bus.alu_op2   = '0;
        bus.alu_ctrl  = 3'b000;
        bus.rsp_valid = '0;
        bus.busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    bus.req_ready[w_grant_idx] = 1'b1;
                    bus.alu_op1  = bus.req_op1[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    bus.alu_op2  = bus.req_op2[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    bus.alu_ctrl = bus.req_ctrl[w_grant_idx*3 +: 3];
                    w_state_nxt  = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.rsp_valid[r_owner] = 1'b1;
                bus.busy               = 1'b1;
                if (bus.rsp_ready[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Compare ops only trust ALU EQ; arithmetic/logic ops only trust SUM.
    assign w_is_cmp = (bus.alu_ctrl >= 3'b101);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDW'(NUM_REQ - 1);
            r_owner      <= '0;
            r_sum        <= '0;
            r_eq         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_vld) begin
                r_owner      <= w_grant_idx;
                r_last_grant <= w_grant_idx;
                r_sum        <= w_is_cmp ? '0 : bus.alu_sum;
                r_eq         <= w_is_cmp ? bus.alu_eq : 1'b0;
            end
        end
    end

    assign bus.rsp_sum = r_sum;
    assign bus.rsp_eq  = r_eq;
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single-cycle ALU (ALUop1/ALUop2/ALUctrl in; SUM/EQ out) between NUM_REQ requesters, e.g. core execute stage and address/branch unit.
- Round-robin grants one request at a time and drives the ALU operands combinationally in the grant cycle.
- Registers the result and holds it in a per-owner response slot until that requester accepts it with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- NUM_REQ, 2, number of requesters (2..8).
- IDW, $clog2(NUM_REQ) (min 1), width of grant index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept; request i consumed when req_valid[i] & req_ready[i].
- req_op1  in  NUM_REQ*DATA_WIDTH  operand 1, slice i for requester i.
- req_op2  in  NUM_REQ*DATA_WIDTH  operand 2, slice i.
- req_ctrl  in  NUM_REQ*3  ALU op, slice i: 000 ADD, 001 SUB, 010 XOR, 011 OR, 100 AND, 101 EQ, 110 LT (unsigned), 111 GE (unsigned).
- alu_op1  out  DATA_WIDTH  to ALU ALUop1.
- alu_op2  out  DATA_WIDTH  to ALU ALUop2.
- alu_ctrl  out  3  to ALU ALUctrl.
- alu_sum  in  DATA_WIDTH  from ALU SUM.
- alu_eq  in  1  from ALU EQ.
- rsp_valid  out  NUM_REQ  one-hot response valid for the owning requester.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_sum  out  DATA_WIDTH  registered result, shared by all requesters.
- rsp_eq  out  1  registered compare flag, shared.
- busy  out  1  high while in RESP.

Behaviour:
- States: IDLE, RESP. Reset: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), rsp_valid=0, rsp_sum=0, rsp_eq=0, owner=0, req_ready=0, busy=0.
- IDLE, no req_valid: req_ready=0; alu_op1/op2=0, alu_ctrl=000.
- IDLE, any req_valid: grant g = first valid index after last_grant, searching cyclically (last_grant+1 … wrapping to last_grant).
  - Same cycle: req_ready[g]=1 (combinational from req_valid and state); alu_* driven from slice g.
  - At edge: capture result, owner<=g, last_grant<=g, state<=RESP.
- Result capture rules:
  - ctrl 000–100: rsp_sum<=alu_sum, rsp_eq<=0.
  - ctrl 101–111: rsp_sum<=0, rsp_eq<=alu_eq.
  - ALU EQ is not trusted for arithmetic ops; SUM is not trusted for compare ops.
- RESP: rsp_valid[owner]=1, all other bits 0; req_ready=0 for all; alu_* held at 0/000; busy=1.
  - When rsp_ready[owner]=1: state<=IDLE, rsp_valid clears next cycle.
  - rsp_ready from non-owners is ignored.
- Timing and throughput:
  - Request-to-response latency is exactly 1 cycle: rsp_valid rises in the cycle after the grant.
  - One operation per 2 cycles maximum; no grant in the same cycle as response acceptance.
  - rsp_sum/rsp_eq stable throughout RESP.
- Backpressure: RESP may last indefinitely; requesters must hold req_valid and operands until req_ready.
  - A requester deasserting req_valid before grant simply drops out of arbitration.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once per NUM_REQ grants.
- Simultaneous events: in IDLE, several valids resolve by round-robin only, with no fixed priority beyond the reset start point.
- Reset mid-operation: rst in RESP discards the pending response (rsp_valid=0 next cycle), restores reset values, and issues no grant in the rst cycle.
- Arithmetic: none performed here; widths pass through unchanged.

Test Plan:
- Single ADD: req0 op1=5, op2=7, ctrl=000 → req_ready[0]=1 same cycle; next cycle rsp_valid=01, rsp_sum=12, rsp_eq=0; rsp_ready[0]=1 → IDLE.
- Compare: req1 op1=3, op2=9, ctrl=110 (LT) → rsp_valid=10, rsp_eq=1, rsp_sum=0; then op1=9, op2=3, ctrl=111 (GE) → rsp_eq=1.
- Round-robin: both valid continuously, req0 SUB 10-4, req1 XOR F0^0F → grants 0,1,0,1; responses 6, FF alternating; no requester granted twice in a row.
- Backpressure: req0 granted, rsp_ready[0]=0 for 5 cycles while req1 valid → rsp_valid[0] and rsp_sum held; req1 not granted until cycle after rsp_ready[0]=1; rsp_ready[1]=1 in RESP ignored.
- Wrap-around: SUB 0-1 → rsp_sum=FFFFFFFF; ADD FFFFFFFF+2 → rsp_sum=1.
- Reset mid-RESP: rst during pending response → next cycle rsp_valid=0, busy=0, rsp_sum=0; with both valid after reset, requester 0 granted first.
